// File: rtl/equeue_param_if.sv
// Bus bundle for equeue_param: dispatch, CDB, issue, flush and occupancy.
// The queue uses the slave modport; the environment driving it uses master.
interface equeue_param_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Dispatch side
    logic [TAG_W-1:0]  dispatch_rdtag;
    logic [TAG_W-1:0]  dispatch_rstag;
    logic [TAG_W-1:0]  dispatch_rttag;
    logic [DATA_W-1:0] dispatch_rsdata;
    logic [DATA_W-1:0] dispatch_rtdata;
    logic              dispatch_rsvalid;
    logic              dispatch_rtvalid;
    logic              dispatch_en;
    logic              dispatch_ready;

    // Common data bus
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;
    logic              cdb_valid;

    logic              flush;

    // Issue side
    logic [TAG_W-1:0]  issue_rdtag;
    logic [DATA_W-1:0] issue_rsdata;
    logic [DATA_W-1:0] issue_rtdata;
    logic              issue_ready;
    logic              issue_done;

    logic [CNT_W-1:0]  occupancy;

    modport master (
        output dispatch_rdtag, dispatch_rstag, dispatch_rttag,
        output dispatch_rsdata, dispatch_rtdata, dispatch_rsvalid, dispatch_rtvalid,
        output dispatch_en, cdb_tag, cdb_data, cdb_valid, flush, issue_done,
        input  dispatch_ready, issue_rdtag, issue_rsdata, issue_rtdata, issue_ready,
        input  occupancy
    );

    modport slave (
        input  dispatch_rdtag, dispatch_rstag, dispatch_rttag,
        input  dispatch_rsdata, dispatch_rtdata, dispatch_rsvalid, dispatch_rtvalid,
        input  dispatch_en, cdb_tag, cdb_data, cdb_valid, flush, issue_done,
        output dispatch_ready, issue_rdtag, issue_rsdata, issue_rtdata, issue_ready,
        output occupancy
    );
endinterface

// File: rtl/equeue_param.sv
// Age-ordered issue queue for one functional unit. Entry 0 is the oldest;
// freed slots collapse in the same edge so age order is kept by position.
// Optional feature: define EQUEUE_DISPATCH_BYPASS_EN to let an operand that
// matches the CDB in its dispatch cycle capture the broadcast data.
module equeue_param #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned TAG_W  = 6,
    parameter int unsigned DATA_W = 32
) (
    input logic       clk,
    input logic       reset,
    equeue_param_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic              valid;
        logic              rs_valid;
        logic              rt_valid;
        logic [TAG_W-1:0]  rd_tag;
        logic [TAG_W-1:0]  rs_tag;
        logic [TAG_W-1:0]  rt_tag;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    entry_t           shift_src [DEPTH+1];
    entry_t           disp_ent;
    logic [CNT_W-1:0] occupancy_q;
    logic [CNT_W-1:0] occupancy_d;
    logic [CNT_W-1:0] wr_idx;
    logic [IDX_W-1:0] sel;
    logic             any_ready;
    logic             issue_ready;
    logic             removed;
    logic             dispatch_ready;
    logic             accept;

    // Capture a CDB broadcast into any pending operand of a live entry.
    function automatic entry_t wakeup(entry_t e, logic cv, logic [TAG_W-1:0] ct,
                                      logic [DATA_W-1:0] cd);
        entry_t r;
        r = e;
        if (e.valid && cv) begin
            if (!e.rs_valid && (e.rs_tag == ct)) begin
                r.rs_valid = 1'b1;
                r.rs_data  = cd;
            end
            if (!e.rt_valid && (e.rt_tag == ct)) begin
                r.rt_valid = 1'b1;
                r.rt_data  = cd;
            end
        end
        return r;
    endfunction

    // Oldest-ready select: lowest index with both operands present.
    always_comb begin
        sel       = '0;
        any_ready = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_q[i].valid && ent_q[i].rs_valid && ent_q[i].rt_valid) begin
                sel       = IDX_W'(i);
                any_ready = 1'b1;
            end
        end
    end

    // Handshake and occupancy bookkeeping.
    always_comb begin
        issue_ready    = any_ready & ~bus.flush & ~reset;
        removed        = issue_ready & bus.issue_done;
        dispatch_ready = ~reset & ~bus.flush & ((occupancy_q < CNT_W'(DEPTH)) | removed);
        accept         = bus.dispatch_en & dispatch_ready;
        // A removal shifts the tail down first, so the free slot moves down too.
        wr_idx         = occupancy_q - CNT_W'(removed);
        occupancy_d    = occupancy_q + CNT_W'(accept) - CNT_W'(removed);
    end

    // Build the incoming entry, optionally folding in a same-cycle CDB match.
    always_comb begin
        disp_ent          = '0;
        disp_ent.valid    = 1'b1;
        disp_ent.rd_tag   = bus.dispatch_rdtag;
        disp_ent.rs_tag   = bus.dispatch_rstag;
        disp_ent.rt_tag   = bus.dispatch_rttag;
        disp_ent.rs_data  = bus.dispatch_rsdata;
        disp_ent.rt_data  = bus.dispatch_rtdata;
        disp_ent.rs_valid = bus.dispatch_rsvalid;
        disp_ent.rt_valid = bus.dispatch_rtvalid;
`ifdef EQUEUE_DISPATCH_BYPASS_EN
        disp_ent = wakeup(disp_ent, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
`endif
    end

    // Next-state per slot: collapse above the issued entry, wake up, then dispatch.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            shift_src[k] = ent_q[k];
        end
        shift_src[DEPTH] = '0;
        for (int j = 0; j < DEPTH; j++) begin
            ent_d[j] = ent_q[j];
            if (removed && (IDX_W'(j) >= sel)) begin
                ent_d[j] = shift_src[j+1];
            end
            // Wakeup applies to the post-shift slot so moving entries never miss a tag.
            ent_d[j] = wakeup(ent_d[j], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            if (accept && (CNT_W'(j) == wr_idx)) begin
                ent_d[j] = disp_ent;
            end
        end
    end

    // State update; reset and flush both wipe every entry including operand state.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            for (int j = 0; j < DEPTH; j++) begin
                ent_q[j] <= '0;
            end
            occupancy_q <= '0;
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                ent_q[j] <= ent_d[j];
            end
            occupancy_q <= occupancy_d;
        end
    end

    assign bus.issue_rdtag    = ent_q[sel].rd_tag;
    assign bus.issue_rsdata   = ent_q[sel].rs_data;
    assign bus.issue_rtdata   = ent_q[sel].rt_data;
    assign bus.issue_ready    = issue_ready;
    assign bus.dispatch_ready = dispatch_ready;
    assign bus.occupancy      = occupancy_q;
endmodule
